ahb_lite_arbiter_2m: RTL and testbench
======================================

AHB_LITE_ARBITER_2M -- requirements
Module: ahb_lite_arbiter_2m

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the AHB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the AHB data width.
REQ-003 SHALL have port HCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have, for each N in {0,1}, the following requester ports:
- mN_req, input, 1: transfer request.
- mN_addr, input, ADDR_WIDTH: byte address.
- mN_write, input, 1: 1 means write.
- mN_size, input, 3: HSIZE value.
- mN_wdata, input, DATA_WIDTH: write data.
REQ-006 SHALL have, for each N in {0,1}, the following response ports:
- mN_gnt, output, 1: one-cycle accept pulse.
- mN_done, output, 1: one-cycle completion pulse.
- mN_rdata, output, DATA_WIDTH: read data.
- mN_err, output, 1: response was HRESP ERROR.
REQ-007 SHALL have AHB-Lite manager outputs:
- HSEL, 1.
- HADDR, ADDR_WIDTH.
- HWRITE, 1.
- HSIZE, 3.
- HBURST, 3.
- HTRANS, 2.
- HWDATA, DATA_WIDTH.
REQ-008 SHALL have AHB-Lite manager inputs:
- HRDATA, DATA_WIDTH.
- HREADY, 1.
- HRESP, 1.

Function
REQ-009 SHALL share one AHB-Lite subordinate between two requesters, issuing SINGLE transfers only; HBURST SHALL always be 3'b000.
REQ-010 SHALL implement FSM IDLE -> ADDR -> DATA; IDLE is entered on reset.
REQ-011 In IDLE, when any mN_req=1, the block SHALL:
- select a winner per REQ-012;
- assert that winner's mN_gnt for exactly one cycle;
- latch its addr, write, size and wdata on that edge;
- enter ADDR.
REQ-012 Arbitration SHALL be round-robin: when both requests are asserted, the requester not served last wins; after reset m0 has priority; a lone requester always wins.
REQ-013 In ADDR, the block SHALL drive HSEL=1, HTRANS=NONSEQ (2'b10), and HADDR/HWRITE/HSIZE from the latched fields; it SHALL enter DATA on an edge with HREADY=1 and stay in ADDR while HREADY=0.
REQ-014 In DATA, the block SHALL drive HWDATA from the latched wdata, HSEL=0 and HTRANS=IDLE, unless REQ-016 applies.
REQ-015 On a DATA edge with HREADY=1, the block SHALL:
- pulse the served requester's mN_done;
- set mN_err=HRESP;
- on a read, load mN_rdata from HRDATA; on a write, leave mN_rdata unchanged.
REQ-016 At DATA completion with a pending request, the block SHALL arbitrate in that same cycle, pulse mN_gnt and go directly to ADDR (no IDLE bubble); otherwise it SHALL go to IDLE.
REQ-017 A requester SHALL hold mN_req and its fields stable until mN_gnt; the block samples fields only in the gnt cycle; a request deasserted before gnt is dropped without a response.
REQ-018 At most one mN_gnt and at most one mN_done SHALL be high in any cycle; gnt and done for the same requester may coincide.
REQ-019 The block SHALL pass HSIZE and address alignment through unchecked; errors are reported only via HRESP -> mN_err.
REQ-020 mN_rdata and mN_err SHALL hold their value until that requester's next done.
REQ-021 Outside ADDR, HADDR/HWRITE/HSIZE SHALL hold their last driven values.
REQ-022 Throughput SHALL be one transfer per 2 cycles with zero wait states; the first done comes 3 cycles after req rises from IDLE.

Reset
REQ-023 On HRESETn=0, the block SHALL immediately (asynchronously):
- enter IDLE;
- set HSEL=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0;
- set all mN_gnt, mN_done and mN_err to 0, and mN_rdata to 0;
- point the round-robin priority at m0.
REQ-024 A reset mid-transfer SHALL abort it, with no done pulse issued for the aborted transfer.

Verification
REQ-025 m0 writes word 0xDEADBEEF to 0x0010, then reads 0x0010 -> m0_done twice; read m0_rdata=0xDEADBEEF; m0_err=0.
REQ-026 m0 and m1 request continuously from reset -> gnt order m0, m1, m0, m1; with zero wait states, gnts are 2 cycles apart.
REQ-027 Subordinate holds HREADY=0 for 3 cycles in ADDR -> HADDR/HTRANS stable throughout; done is delayed by exactly 3 cycles.
REQ-028 m1 reads with size 3'b011 and the subordinate returns HRESP=1 -> m1_done with m1_err=1; m0_err unchanged.
REQ-029 Assert HRESETn=0 while in DATA -> no done pulse; all outputs at reset values; next arbitration favours m0.

Source files
------------

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-requester front end for one AHB-Lite subordinate: round-robin arbitration,
// SINGLE transfers only, with per-requester grant/done pulses and read data.
module ahb_lite_arbiter_2m #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic [2:0]            m0_size,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic [2:0]            m1_size,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [1:0]            HTRANS,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                state;
  logic                  own;   // requester owning the transfer in flight
  logic                  last;  // requester served most recently
  logic                  win, any_req, done_now, launch;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign HBURST   = 3'b000;
  assign any_req  = m0_req | m1_req;
  assign win      = (m0_req & m1_req) ? ~last : m1_req;
  assign done_now = (state == DATA) & HREADY;
  // Back-to-back: a completing data phase re-arbitrates in the same cycle.
  assign launch   = any_req & ((state == IDLE) | done_now);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      own      <= 1'b0;
      last     <= 1'b1;
      wdata_q  <= '0;
      HSEL     <= 1'b0;
      HTRANS   <= 2'b00;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= 3'b000;
      HWDATA   <= '0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;

      if (state == ADDR && HREADY) begin
        state  <= DATA;
        HSEL   <= 1'b0;
        HTRANS <= 2'b00;
        HWDATA <= wdata_q;
      end

      if (done_now) begin
        state <= IDLE;
        if (own) begin
          m1_done <= 1'b1;
          m1_err  <= HRESP;
          if (!HWRITE) m1_rdata <= HRDATA;
        end else begin
          m0_done <= 1'b1;
          m0_err  <= HRESP;
          if (!HWRITE) m0_rdata <= HRDATA;
        end
      end

      // HADDR/HWRITE/HSIZE double as the latched request fields.
      if (launch) begin
        state   <= ADDR;
        own     <= win;
        last    <= win;
        HSEL    <= 1'b1;
        HTRANS  <= 2'b10;
        if (win) begin
          m1_gnt  <= 1'b1;
          HADDR   <= m1_addr;
          HWRITE  <= m1_write;
          HSIZE   <= m1_size;
          wdata_q <= m1_wdata;
        end else begin
          m0_gnt  <= 1'b1;
          HADDR   <= m0_addr;
          HWRITE  <= m0_write;
          HSIZE   <= m0_size;
          wdata_q <= m0_wdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench: small AHB memory subordinate, done scoreboard, grant log.
module tb_ahb_lite_arbiter_2m;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m0_req, m1_req, m0_write, m1_write;
  logic [15:0] m0_addr, m1_addr;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        HSEL, HWRITE, HREADY, HRESP;
  logic [15:0] HADDR;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;

  ahb_lite_arbiter_2m #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  typedef struct {
    logic        m;
    logic        err;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];
  logic gwho[$];
  int   gcyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Subordinate: 16-word memory, data phase tracked from accepted address phases.
  logic [31:0] mem [0:15];
  logic        dp_v, dp_w, resp_err;
  logic [3:0]  dp_a;
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dp_v <= 1'b0; dp_w <= 1'b0; dp_a <= 4'd0;
    end else if (HREADY) begin
      if (dp_v && dp_w) mem[dp_a] <= HWDATA;
      dp_v <= HSEL && HTRANS[1];
      dp_a <= HADDR[5:2];
      dp_w <= HWRITE;
    end
  assign HRDATA = mem[dp_a];
  assign HRESP  = resp_err & dp_v;

  always @(posedge HCLK) cyc++;

  always @(negedge HCLK)
    if (HRESETn && (m0_gnt || m1_gnt)) begin
      chk("one_gnt", m0_gnt & m1_gnt, 0);
      gwho.push_back(m1_gnt);
      gcyc.push_back(cyc);
    end

  always @(negedge HCLK)
    if (HRESETn && (m0_done || m1_done)) begin
      exp_t e;
      chk("one_done", m0_done & m1_done, 0);
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_underflow: observed done with no expected entry");
      end else begin
        e = sb.pop_front();
        chk("done_who", m1_done, e.m);
        chk("done_err", m1_done ? m1_err : m0_err, e.err);
        chk("done_rdata", m1_done ? m1_rdata : m0_rdata, e.rd);
      end
      done_cnt++;
      last_done_cyc = cyc;
    end

  function automatic void push_exp(input logic m, input logic err, input logic [31:0] rd);
    exp_t e;
    e.m = m; e.err = err; e.rd = rd;
    sb.push_back(e);
  endfunction

  task automatic raise(input logic m, input logic [15:0] a, input logic w,
                       input logic [2:0] s, input logic [31:0] d);
    if (m) begin m1_req = 1; m1_addr = a; m1_write = w; m1_size = s; m1_wdata = d; end
    else   begin m0_req = 1; m0_addr = a; m0_write = w; m0_size = s; m0_wdata = d; end
  endtask

  task automatic wait_gnt(input logic m);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge HCLK); #1;
      seen = m ? m1_gnt : m0_gnt;
    end
    if (!seen) begin
      checks++; errors++;
      $error("FAIL gnt_timeout: observed no gnt for m%0d expected gnt", m);
    end
    if (m) m1_req = 0; else m0_req = 0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_cnt < target; i++) begin
      @(negedge HCLK); #1;
    end
    if (done_cnt < target) begin
      checks++; errors++;
      $error("FAIL done_timeout: observed %0d dones expected %0d", done_cnt, target);
    end
  endtask

  task automatic check_reset();
    chk("rst_hsel", HSEL, 0);     chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);   chk("rst_hwrite", HWRITE, 0);
    chk("rst_hsize", HSIZE, 0);   chk("rst_hburst", HBURST, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_done", {m0_done, m1_done}, 0);
    chk("rst_err", {m0_err, m1_err}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
  endtask

  initial begin
    int req_cyc, base, gbase, cnt;
    HRESETn = 0; HREADY = 1; resp_err = 0;
    m0_req = 0; m0_addr = 0; m0_write = 0; m0_size = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_write = 0; m1_size = 0; m1_wdata = 0;
    repeat (3) @(negedge HCLK);
    #1 check_reset();
    @(negedge HCLK); HRESETn = 1;
    @(negedge HCLK); #1;

    // Write then read back through the subordinate memory.
    push_exp(0, 0, 32'h0);
    req_cyc = cyc;
    raise(0, 16'h0010, 1, 3'b010, 32'hDEADBEEF);
    wait_gnt(0);
    chk("addr_hsel", HSEL, 1);  chk("addr_htrans", HTRANS, 2'b10);
    chk("addr_haddr", HADDR, 16'h0010); chk("addr_hwrite", HWRITE, 1);
    chk("addr_hburst", HBURST, 0);
    wait_done(1);
    chk("first_latency", last_done_cyc - req_cyc, 3);
    push_exp(0, 0, 32'hDEADBEEF);
    raise(0, 16'h0010, 0, 3'b010, 32'h0);
    wait_gnt(0);
    wait_done(2);

    // Continuous requests from both sides after a fresh reset.
    @(negedge HCLK); HRESETn = 0;
    @(negedge HCLK); HRESETn = 1;
    @(negedge HCLK); #1;
    base = done_cnt; gbase = gwho.size();
    push_exp(0, 0, 32'hDEADBEEF); push_exp(1, 0, 32'hA5A5_0009);
    push_exp(0, 0, 32'hDEADBEEF); push_exp(1, 0, 32'hA5A5_0009);
    raise(0, 16'h0010, 0, 3'b010, 32'h0);
    raise(1, 16'h0024, 0, 3'b010, 32'h0);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(negedge HCLK); #1;
      if (m0_gnt || m1_gnt) cnt++;
    end
    m0_req = 0; m1_req = 0;
    chk("rr_gnt_count", cnt, 4);
    wait_done(base + 4);
    if (gwho.size() >= gbase + 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", gwho[gbase+k], k % 2);
      for (int k = 1; k < 4; k++) chk("rr_spacing", gcyc[gbase+k] - gcyc[gbase+k-1], 2);
    end else chk("rr_gnt_log", gwho.size() - gbase, 4);

    // Address-phase wait states hold the bus and delay done.
    @(negedge HCLK); #1;
    base = done_cnt;
    push_exp(0, 0, 32'hA5A5_000C);
    req_cyc = cyc;
    raise(0, 16'h0030, 0, 3'b010, 32'h0);
    wait_gnt(0);
    HREADY = 0;
    for (int k = 0; k < 4; k++) begin
      chk("wait_haddr", HADDR, 16'h0030);
      chk("wait_htrans", HTRANS, 2'b10);
      if (k < 3) begin @(negedge HCLK); #1; end
    end
    HREADY = 1;
    wait_done(base + 1);
    chk("wait_latency", last_done_cyc - req_cyc, 6);

    // Error response on an m1 doubleword read.
    @(negedge HCLK); #1;
    base = done_cnt;
    resp_err = 1;
    push_exp(1, 1, 32'hA5A5_0009);
    raise(1, 16'h0024, 0, 3'b011, 32'h0);
    wait_gnt(1);
    chk("err_hsize", HSIZE, 3'b011);
    wait_done(base + 1);
    resp_err = 0;
    chk("err_m0_unchanged", m0_err, 0);
    repeat (2) @(negedge HCLK); #1;
    chk("err_m1_held", m1_err, 1);

    // Reset during an m0 data phase: abort, no done, priority back to m0.
    base = done_cnt;
    raise(0, 16'h0010, 0, 3'b010, 32'h0);
    wait_gnt(0);
    @(negedge HCLK); #1;
    chk("abort_in_data", HSEL, 0);
    HRESETn = 0;
    #1 check_reset();
    repeat (3) @(negedge HCLK);
    HRESETn = 1;
    repeat (2) @(negedge HCLK); #1;
    chk("abort_no_done", done_cnt, base);
    gbase = gwho.size();
    push_exp(0, 0, 32'hDEADBEEF); push_exp(1, 0, 32'hA5A5_0009);
    raise(0, 16'h0010, 0, 3'b010, 32'h0);
    raise(1, 16'h0024, 0, 3'b010, 32'h0);
    wait_gnt(0);
    chk("post_rst_first_gnt", (gwho.size() > gbase) ? gwho[gbase] : 1'bx, 0);
    wait_gnt(1);
    wait_done(base + 2);

    repeat (3) @(negedge HCLK);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
